// File: rtl/operand_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : operand_fetch
//  Brief    : Operand-fetch / writeback stage around the 8-bit ALU. Reads a
//             small register file (r0 hard-wired to zero), registers the
//             operands and opcode for the ALU, and writes the ALU result
//             and zero flag back one cycle later.
//             Compile-time option FORWARD_EN: when defined, a source that
//             matches the instruction in execute takes alu_result directly.
//             When undefined, such an instruction is held off for one cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module operand_fetch #(
  parameter int NREG = 8,
  parameter int AW   = 3,
  parameter int DW   = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    in_op,
  input  logic [AW-1:0] in_rd,
  input  logic [AW-1:0] in_rs1,
  input  logic [AW-1:0] in_rs2,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [1:0]    alu_sel,
  input  logic [DW-1:0] alu_result,
  input  logic          alu_zero,
  output logic          ex_valid,
  output logic          zero_flag,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data
);

  // Opcode whose second operand is ignored by the ALU.
  localparam logic [1:0]    c_OP_NOTA = 2'b10;
  localparam logic [AW-1:0] c_R0      = '0;

  // Architectural state.
  logic [DW-1:0] rf_q [NREG];

  // Execute-slot state.
  logic          ex_valid_q,  ex_valid_d;
  logic [AW-1:0] ex_rd_q,     ex_rd_d;
  logic [DW-1:0] alu_a_q,     alu_a_d;
  logic [DW-1:0] alu_b_q,     alu_b_d;
  logic [1:0]    alu_sel_q,   alu_sel_d;
  logic          zero_flag_q, zero_flag_d;

  // Source/execute matching and operand selection.
  logic          w_ex_writes;
  logic          w_hit_rs1;
  logic          w_hit_rs2;
  logic [DW-1:0] w_rf_rs1;
  logic [DW-1:0] w_rf_rs2;
  logic [DW-1:0] w_opa;
  logic [DW-1:0] w_opb;
  logic          w_accept;

  // The instruction in execute will write a real register at the next edge.
  assign w_ex_writes = ex_valid_q && (ex_rd_q != c_R0);

  // A source matches when it names that register; rs2 is irrelevant for not-a.
  assign w_hit_rs1 = w_ex_writes && (in_rs1 == ex_rd_q);
  assign w_hit_rs2 = w_ex_writes && (in_rs2 == ex_rd_q) && (in_op != c_OP_NOTA);

  // Plain register-file reads; r0 always reads zero.
  assign w_rf_rs1 = (in_rs1 == c_R0) ? '0 : rf_q[in_rs1];
  assign w_rf_rs2 = (in_rs2 == c_R0) ? '0 : rf_q[in_rs2];

`ifdef FORWARD_EN
  // A matching source picks up the result being written this very edge.
  assign w_opa    = w_hit_rs1 ? alu_result : w_rf_rs1;
  assign w_opb    = w_hit_rs2 ? alu_result : w_rf_rs2;
  assign in_ready = 1'b1;
`else
  logic w_hazard;

  // Without forwarding a matching reader waits one cycle for the writeback,
  // after which the slot is empty and the updated register is read directly.
  assign w_hazard = w_hit_rs1 || w_hit_rs2;
  assign w_opa    = w_rf_rs1;
  assign w_opb    = w_rf_rs2;
  assign in_ready = ~(in_valid & w_hazard);
`endif

  assign w_accept = in_valid & in_ready;

  // Next-state for the execute slot and the retired zero flag.
  always_comb begin
    ex_valid_d  = w_accept;
    ex_rd_d     = ex_rd_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_sel_d   = alu_sel_q;
    zero_flag_d = zero_flag_q;
    if (w_accept) begin
      ex_rd_d   = in_rd;
      alu_a_d   = w_opa;
      alu_b_d   = w_opb;
      alu_sel_d = in_op;
    end
    if (ex_valid_q) begin
      zero_flag_d = alu_zero;
    end
  end

  // Execute-slot registers; reset discards any in-flight instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q  <= 1'b0;
      ex_rd_q     <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= 2'b00;
      zero_flag_q <= 1'b0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_rd_q     <= ex_rd_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_sel_q   <= alu_sel_d;
      zero_flag_q <= zero_flag_d;
    end
  end

  // Register file writeback; entry 0 is never written so it stays zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= '0;
      end
    end else if (w_ex_writes) begin
      rf_q[ex_rd_q] <= alu_result;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign ex_valid  = ex_valid_q;
  assign zero_flag = zero_flag_q;
  assign dbg_data  = (dbg_addr == c_R0) ? '0 : rf_q[dbg_addr];

endmodule
`default_nettype wire

// File: tb/tb_operand_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_operand_fetch
//  Brief    : Scoreboard bench for operand_fetch. Stimulus pushes expected
//             operands/results computed from sequential register semantics;
//             a monitor pops and compares as instructions reach execute and
//             retire. Honours FORWARD_EN the same way as the design.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_operand_fetch;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_op;
  logic [2:0] in_rd, in_rs1, in_rs2;
  logic [7:0] alu_a, alu_b;
  logic [1:0] alu_sel;
  logic [7:0] alu_result;
  logic       alu_zero;
  logic       ex_valid;
  logic       zero_flag;
  logic [2:0] dbg_addr;
  logic [7:0] dbg_data;

  logic       mon_en;
  logic [2:0] mon_addr, tb_addr;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0] rd;
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       z;
  } exp_t;

  exp_t       q[$];
  logic [7:0] mrf [8];
  bit         ex_live;
  logic [2:0] ex_rd_m;

  operand_fetch #(.NREG(8), .AW(3), .DW(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_result(alu_result),
    .alu_zero  (alu_zero),
    .ex_valid  (ex_valid),
    .zero_flag (zero_flag),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data)
  );

  function automatic logic [7:0] alu_fn(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      2'b01:   return a - b;
      2'b10:   return ~a;
      default: return a + b;
    endcase
  endfunction

  // Environment ALU feeding the stage.
  assign alu_result = alu_fn(alu_sel, alu_a, alu_b);
  assign alu_zero   = (alu_result == 8'h00);
  assign dbg_addr   = mon_en ? mon_addr : tb_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mrf[i] = 8'h00;
    ex_live = 0;
  endtask

  task automatic check_reset_state();
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_sel", alu_sel, 0);
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_zero_flag", zero_flag, 0);
    chk("rst_in_ready", in_ready, 1);
    for (int i = 0; i < 8; i++) begin
      tb_addr = 3'(i);
      #1;
      chk("rst_dbg_data", dbg_data, 0);
    end
  endtask

  // Issue one instruction; returns just after its accepting edge.
  task automatic issue(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                       input logic [2:0] rs2, input bit push);
    exp_t e;
    bit   exp_stall;
    int   waits;
    exp_stall = 0;
`ifndef FORWARD_EN
    exp_stall = ex_live && (ex_rd_m != 3'd0) &&
                ((rs1 == ex_rd_m) || ((op != 2'b10) && (rs2 == ex_rd_m)));
`endif
    in_valid = 1'b1;
    in_op    = op;
    in_rd    = rd;
    in_rs1   = rs1;
    in_rs2   = rs2;
    #1;
    chk("in_ready", in_ready, exp_stall ? 0 : 1);
    waits = 0;
    while (!in_ready && waits < 4) begin
      @(posedge clk);
      #1;
      waits++;
    end
    if (!in_ready) begin
      chk("accept_timeout", in_ready, 1);
      in_valid = 1'b0;
      ex_live  = 0;
      return;
    end
    chk("stall_cycles", waits, exp_stall ? 1 : 0);
    e.rd  = rd;
    e.op  = op;
    e.a   = (rs1 == 3'd0) ? 8'h00 : mrf[rs1];
    e.b   = (rs2 == 3'd0) ? 8'h00 : mrf[rs2];
    e.res = alu_fn(op, e.a, e.b);
    e.z   = (e.res == 8'h00);
    if (push) q.push_back(e);
    if (rd != 3'd0) mrf[rd] = e.res;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    ex_live  = 1;
    ex_rd_m  = rd;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    ex_live = 0;
  endtask

  // Monitor: operands when an instruction sits in execute, rf/zero after it retires.
  initial begin
    exp_t e;
    exp_t pend_e;
    bit   pend;
    pend = 0;
    forever begin
      @(negedge clk);
      if (!rst_n || !mon_en) begin
        pend = 0;
      end else begin
        if (pend) begin
          chk("wb_zero_flag", zero_flag, pend_e.z);
          chk("wb_rf", dbg_data, (pend_e.rd == 3'd0) ? 8'h00 : pend_e.res);
          pend = 0;
        end
        if (ex_valid) begin
          if (q.size() == 0) begin
            chk("unexpected_ex_valid", ex_valid, 0);
          end else begin
            e = q.pop_front();
            chk("alu_a", alu_a, e.a);
            if (e.op != 2'b10) chk("alu_b", alu_b, e.b);
            chk("alu_sel", alu_sel, e.op);
            pend_e   = e;
            pend     = 1;
            mon_addr = e.rd;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] rd, rs1, rs2, last_rd;
    logic [1:0] op;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_op    = 2'b00;
    in_rd    = 3'd0;
    in_rs1   = 3'd0;
    in_rs2   = 3'd0;
    mon_en   = 1'b0;
    mon_addr = 3'd0;
    tb_addr  = 3'd0;
    model_reset();
    #2;
    check_reset_state();
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Seed from r0 and write/readback.
    issue(2'b00, 3'd1, 3'd0, 3'd0, 1);   // r1 = r0 + r0
    issue(2'b10, 3'd2, 3'd1, 3'd0, 1);   // r2 = ~r1 = FF
    issue(2'b01, 3'd3, 3'd2, 3'd2, 1);   // r3 = r2 - r2 = 0
    idle(1);
    // Back-to-back dependent pair.
    issue(2'b00, 3'd4, 3'd2, 3'd2, 1);   // r4 = FE
    issue(2'b00, 3'd5, 3'd4, 3'd2, 1);   // r5 = FD
    idle(1);
    // r0 destination, then a reader of r0.
    issue(2'b00, 3'd3, 3'd2, 3'd0, 1);   // r3 = FF
    idle(1);
    issue(2'b01, 3'd0, 3'd2, 3'd3, 1);   // r0 = r2 - r3 (discarded), zero 1
    issue(2'b00, 3'd6, 3'd0, 3'd0, 1);   // reader of r0: no stall
    // not-a ignores rs2.
    issue(2'b00, 3'd6, 3'd2, 3'd0, 1);   // r6 = FF
    issue(2'b10, 3'd7, 3'd1, 3'd6, 1);   // r7 = ~r1 = FF, no stall
    idle(2);

    // Randomized traffic, biased toward dependent pairs.
    last_rd = 3'd1;
    for (int n = 0; n < 300; n++) begin
      op  = 2'($urandom_range(0, 3));
      rd  = 3'($urandom_range(0, 7));
      rs1 = ($urandom_range(0, 1) == 0) ? last_rd : 3'($urandom_range(0, 7));
      rs2 = ($urandom_range(0, 2) == 0) ? last_rd : 3'($urandom_range(0, 7));
      issue(op, rd, rs1, rs2, 1);
      last_rd = rd;
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(3);

    // Asynchronous reset asserted mid-cycle.
    mon_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state();
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    model_reset();

    // Reset while an instruction occupies execute.
    issue(2'b10, 3'd2, 3'd0, 3'd0, 1);   // r2 = FF
    idle(2);
    issue(2'b00, 3'd1, 3'd2, 3'd2, 0);   // r1 = r2 + r2, never retires
    chk("ex_valid_inflight", ex_valid, 1);
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk("mid_rst_ex_valid", ex_valid, 0);
    chk("mid_rst_zero_flag", zero_flag, 0);
    tb_addr = 3'd1;
    #1;
    chk("mid_rst_rf1", dbg_data, 0);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    model_reset();
    chk("post_rst_ex_valid", ex_valid, 0);
    issue(2'b00, 3'd3, 3'd1, 3'd0, 1);   // r3 = r1 + r0 = 0
    idle(3);

    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
